// File: rtl/pwm_audio_capture.sv
// Recovers the duty value of an external PWM stream (period 2^N clk) as a high-clock count per window.
// Frames align to rising edges. A timeout alignment handles inputs with no edges (0% / 100%).
module pwm_audio_capture #(
    parameter int N            = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pwm_in,
    output logic [N:0]   duty_val,
    output logic         duty_valid,
    output logic         locked
);

    localparam int HW = N + 1;
    localparam int LW = $clog2(LOCK_WINDOWS + 1);

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;
    logic                   s;
    logic                   rise;
    logic                   win_last;

    state_t          state_reg,    state_next;
    logic [N-1:0]    wcnt_reg,     wcnt_next;
    logic [HW-1:0]   hi_cnt_reg,   hi_cnt_next;
    logic [LW-1:0]   lock_cnt_reg, lock_cnt_next;
    logic            locked_reg,   locked_next;
    logic [HW-1:0]   duty_val_reg, duty_val_next;
    logic            duty_valid_reg, duty_valid_next;

    // Synchroniser chain: stage 0 samples the asynchronous input.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= pwm_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign s        = sync_reg[SYNC_STAGES-1];
    assign rise     = s & ~s_d_reg;
    assign win_last = (wcnt_reg == {N{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_reg        <= 1'b0;
            state_reg      <= SEARCH;
            wcnt_reg       <= '0;
            hi_cnt_reg     <= '0;
            lock_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
            duty_val_reg   <= '0;
            duty_valid_reg <= 1'b0;
        end else begin
            s_d_reg        <= s;
            state_reg      <= state_next;
            wcnt_reg       <= wcnt_next;
            hi_cnt_reg     <= hi_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            locked_reg     <= locked_next;
            duty_val_reg   <= duty_val_next;
            duty_valid_reg <= duty_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wcnt_next       = wcnt_reg + N'(1);
        hi_cnt_next     = hi_cnt_reg;
        lock_cnt_next   = lock_cnt_reg;
        locked_next     = locked_reg;
        duty_val_next   = duty_val_reg;
        duty_valid_next = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (rise) begin
                    // The rising-edge cycle itself is high sample 0.
                    state_next  = MEASURE;
                    wcnt_next   = N'(1);
                    hi_cnt_next = HW'(1);
                end else if (win_last) begin
                    state_next  = MEASURE;
                    wcnt_next   = '0;
                    hi_cnt_next = '0;
                end
            end
            MEASURE: begin
                hi_cnt_next = hi_cnt_reg + HW'(s);
                if (rise && (wcnt_reg != '0)) begin
                    // Misplaced edge (also at the last slot): drop the window and restart on it.
                    wcnt_next     = N'(1);
                    hi_cnt_next   = HW'(1);
                    lock_cnt_next = '0;
                    locked_next   = 1'b0;
                end else if (win_last) begin
                    duty_val_next   = hi_cnt_reg + HW'(s);
                    duty_valid_next = 1'b1;
                    hi_cnt_next     = '0;
                    if (lock_cnt_reg != LW'(LOCK_WINDOWS))
                        lock_cnt_next = lock_cnt_reg + LW'(1);
                    if (lock_cnt_reg >= LW'(LOCK_WINDOWS - 1))
                        locked_next = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    assign duty_val   = duty_val_reg;
    assign duty_valid = duty_valid_reg;
    assign locked     = locked_reg;

endmodule
